// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl - write-back controller for the general register file.
//
// Merges two write sources onto the single register-file write port:
//   - main datapath: single-cycle writes, always highest priority.
//   - auxiliary long-latency unit: valid/ready handshake, buffered in a
//     small FIFO of DEPTH entries and drained whenever main is idle.
// Also exports per-register pending flags so hazard logic can stall reads
// of registers that still have a queued aux write.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   main_we/addr/data/pc         main datapath write request
//   aux_valid/ready/addr/data/pc aux result handshake
//   RegWr, A3, res, WPC          register file write port (combinational)
//   q1_addr/q1_pend, q2_addr/q2_pend  hazard queries against the FIFO
module grf_wb_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        main_we,
  input  logic [4:0]  main_addr,
  input  logic [31:0] main_data,
  input  logic [31:0] main_pc,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  input  logic [31:0] aux_pc,
  output logic        RegWr,
  output logic [4:0]  A3,
  output logic [31:0] res,
  output logic [31:0] WPC,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_pend,
  output logic        q2_pend
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // FIFO storage; live_q is kept 0 for unoccupied slots so pending lookup
  // needs no occupancy mask.
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic mw;
  logic empty;
  logic full;
  logic head_live;
  logic bypass;
  logic pop;
  logic push;

  // Control decode and write port select
  always_comb begin
    mw        = main_we && (main_addr != '0);
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    head_live = !empty && live_q[rd_ptr_q];
    aux_ready = !full;
    // Bypass only when the FIFO is empty, so it never jumps older entries.
    bypass    = !mw && empty && aux_valid && (aux_addr != '0);
    // A live head waits while main owns the port; a dead head pops anyway.
    pop       = !empty && (!mw || !head_live);
    push      = aux_valid && !full && (aux_addr != '0) && !bypass &&
                !(mw && (aux_addr == main_addr));

    RegWr = 1'b0;
    A3    = '0;
    res   = '0;
    WPC   = '0;
    if (mw) begin
      RegWr = 1'b1;
      A3    = main_addr;
      res   = main_data;
      WPC   = main_pc;
    end else if (head_live) begin
      RegWr = 1'b1;
      A3    = addr_q[rd_ptr_q];
      res   = data_q[rd_ptr_q];
      WPC   = pc_q[rd_ptr_q];
    end else if (bypass) begin
      RegWr = 1'b1;
      A3    = aux_addr;
      res   = aux_data;
      WPC   = aux_pc;
    end
  end

  // FIFO next state
  always_comb begin
    live_d   = live_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Main is always the younger write: kill matching queued entries.
    if (mw) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == main_addr) begin
          live_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // Push slot is never occupied (push requires !full), so no conflict
    // with the kill or pop updates above.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q] = aux_addr;
      data_d[wr_ptr_q] = aux_data;
      pc_d[wr_ptr_q]   = aux_pc;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending lookup reflects registered state only.
  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == q1_addr)) q1_pend = 1'b1;
      if (live_q[i] && (addr_q[i] == q2_addr)) q2_pend = 1'b1;
    end
    if (q1_addr == '0) q1_pend = 1'b0;
    if (q2_addr == '0) q2_pend = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload fields need no reset; live_q guards their use.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_grf_wb_ctrl.sv
module tb_grf_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        main_we;
  logic [4:0]  main_addr;
  logic [31:0] main_data;
  logic [31:0] main_pc;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [31:0] aux_pc;
  logic        RegWr;
  logic [4:0]  A3;
  logic [31:0] res;
  logic [31:0] WPC;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_pend;
  logic        q2_pend;

  int n_checks = 0;
  int n_fail   = 0;

  grf_wb_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .main_we   (main_we),
    .main_addr (main_addr),
    .main_data (main_data),
    .main_pc   (main_pc),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .aux_pc    (aux_pc),
    .RegWr     (RegWr),
    .A3        (A3),
    .res       (res),
    .WPC       (WPC),
    .q1_addr   (q1_addr),
    .q2_addr   (q2_addr),
    .q1_pend   (q1_pend),
    .q2_pend   (q2_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [31:0] mpc;
    logic        av;
    logic [4:0]  aaddr;
    logic [31:0] adata;
    logic [31:0] apc;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        chk;
    logic        ewr;
    logic [4:0]  ea3;
    logic [31:0] eres;
    logic [31:0] ewpc;
    logic        erdy;
    logic        ep1;
    logic        ep2;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(
    logic rst, logic mwe, logic [4:0] maddr, logic [31:0] mdata, logic [31:0] mpc,
    logic av, logic [4:0] aaddr, logic [31:0] adata, logic [31:0] apc,
    logic [4:0] q1, logic [4:0] q2, logic chk,
    logic ewr, logic [4:0] ea3, logic [31:0] eres, logic [31:0] ewpc,
    logic erdy, logic ep1, logic ep2);
    vec_t v;
    v.rst = rst; v.mwe = mwe; v.maddr = maddr; v.mdata = mdata; v.mpc = mpc;
    v.av = av; v.aaddr = aaddr; v.adata = adata; v.apc = apc;
    v.q1 = q1; v.q2 = q2; v.chk = chk;
    v.ewr = ewr; v.ea3 = ea3; v.eres = eres; v.ewpc = ewpc;
    v.erdy = erdy; v.ep1 = ep1; v.ep2 = ep2;
    vecs.push_back(v);
  endfunction

  task automatic drive_idle();
    reset = 1'b0; main_we = 1'b0; main_addr = '0; main_data = '0; main_pc = '0;
    aux_valid = 1'b0; aux_addr = '0; aux_data = '0; aux_pc = '0;
    q1_addr = '0; q2_addr = '0;
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [4:0]  got_a3[$];
  logic [31:0] got_res[$];

  initial begin
    drive_idle();

    //   rst mwe maddr mdata    mpc      av aaddr adata   apc      q1  q2 chk  wr a3  res      wpc      rdy p1 p2
    // reset
    addv(1, 0, 0,  0,       0,       0, 0,  0,      0,       0,  0, 0,   0, 0,  0,       0,       1,  0, 0);
    addv(1, 0, 0,  0,       0,       0, 0,  0,      0,       0,  0, 1,   0, 0,  0,       0,       1,  0, 0);
    // main write lands in the same cycle
    addv(0, 1, 8,  'h11,    'h100,   0, 0,  0,      0,       0,  0, 1,   1, 8,  'h11,    'h100,   1,  0, 0);
    // aux bypass with empty FIFO; never pending
    addv(0, 0, 0,  0,       0,       1, 9,  'h22,   'h200,   9,  0, 1,   1, 9,  'h22,    'h200,   1,  0, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       9,  0, 1,   0, 0,  0,       0,       1,  0, 0);
    // main busy, aux 1..5 offered; FIFO fills at 4
    addv(0, 1, 20, 'h30,    'h300,   1, 1,  'h41,   'h401,   1,  4, 1,   1, 20, 'h30,    'h300,   1,  0, 0);
    addv(0, 1, 20, 'h31,    'h301,   1, 2,  'h42,   'h402,   1,  4, 1,   1, 20, 'h31,    'h301,   1,  1, 0);
    addv(0, 1, 20, 'h32,    'h302,   1, 3,  'h43,   'h403,   1,  4, 1,   1, 20, 'h32,    'h302,   1,  1, 0);
    addv(0, 1, 20, 'h33,    'h303,   1, 4,  'h44,   'h404,   1,  4, 1,   1, 20, 'h33,    'h303,   1,  1, 0);
    addv(0, 1, 20, 'h34,    'h304,   1, 5,  'h45,   'h405,   1,  4, 1,   1, 20, 'h34,    'h304,   0,  1, 1);
    // main idle: drain in order; ready stays low while full even as head pops
    addv(0, 0, 0,  0,       0,       1, 5,  'h45,   'h405,   1,  4, 1,   1, 1,  'h41,    'h401,   0,  1, 1);
    addv(0, 0, 0,  0,       0,       1, 5,  'h45,   'h405,   1,  4, 1,   1, 2,  'h42,    'h402,   1,  0, 1);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       1,  4, 1,   1, 3,  'h43,    'h403,   1,  0, 1);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       1,  4, 1,   1, 4,  'h44,    'h404,   1,  0, 1);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       1,  4, 1,   1, 5,  'h45,    'h405,   1,  0, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       1,  4, 1,   0, 0,  0,       0,       1,  0, 0);
    // WAW kill: queued $7=0xA superseded by main $7=0xB
    addv(0, 1, 21, 'h50,    'h500,   1, 7,  'hA,    'h70A,   7,  0, 1,   1, 21, 'h50,    'h500,   1,  0, 0);
    addv(0, 1, 7,  'hB,     'h70B,   0, 0,  0,      0,       7,  0, 1,   1, 7,  'hB,     'h70B,   1,  1, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       7,  0, 1,   0, 0,  0,       0,       1,  0, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       7,  0, 1,   0, 0,  0,       0,       1,  0, 0);
    // main to $0 yields to the FIFO head; aux to $0 is dropped
    addv(0, 1, 22, 'h60,    'h600,   1, 12, 'hC,    'h70C,   12, 0, 1,   1, 22, 'h60,    'h600,   1,  0, 0);
    addv(0, 1, 0,  'h99,    'h999,   1, 0,  'hD,    'h70D,   12, 0, 1,   1, 12, 'hC,     'h70C,   1,  1, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       12, 0, 1,   0, 0,  0,       0,       1,  0, 0);
    addv(0, 0, 0,  0,       0,       1, 0,  'hE,    'h70E,   0,  0, 1,   0, 0,  0,       0,       1,  0, 0);
    // same-cycle clash: aux to main's register is discarded
    addv(0, 1, 13, 'h13,    'h130,   1, 13, 'hF,    'h70F,   13, 0, 1,   1, 13, 'h13,    'h130,   1,  0, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       13, 0, 1,   0, 0,  0,       0,       1,  0, 0);
    // fill 3 entries, then reset drops them
    addv(0, 1, 23, 'h23,    'h230,   1, 1,  'h71,   'h771,   1,  2, 1,   1, 23, 'h23,    'h230,   1,  0, 0);
    addv(0, 1, 23, 'h24,    'h231,   1, 2,  'h72,   'h772,   1,  2, 1,   1, 23, 'h24,    'h231,   1,  1, 0);
    addv(0, 1, 23, 'h25,    'h232,   1, 3,  'h73,   'h773,   1,  3, 1,   1, 23, 'h25,    'h232,   1,  1, 0);
    addv(1, 0, 0,  0,       0,       0, 0,  0,      0,       1,  2, 1,   1, 1,  'h71,    'h771,   1,  1, 1);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       1,  3, 1,   0, 0,  0,       0,       1,  0, 0);
    addv(0, 0, 0,  0,       0,       0, 0,  0,      0,       2,  0, 1,   0, 0,  0,       0,       1,  0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      main_we   = vecs[i].mwe;
      main_addr = vecs[i].maddr;
      main_data = vecs[i].mdata;
      main_pc   = vecs[i].mpc;
      aux_valid = vecs[i].av;
      aux_addr  = vecs[i].aaddr;
      aux_data  = vecs[i].adata;
      aux_pc    = vecs[i].apc;
      q1_addr   = vecs[i].q1;
      q2_addr   = vecs[i].q2;
      #2;
      if (vecs[i].chk) begin
        n_checks++;
        if ({RegWr, A3, res, WPC, aux_ready, q1_pend, q2_pend} !==
            {vecs[i].ewr, vecs[i].ea3, vecs[i].eres, vecs[i].ewpc,
             vecs[i].erdy, vecs[i].ep1, vecs[i].ep2}) begin
          n_fail++;
          $display("FAIL vec%0d: got RegWr=%0b A3=%0d res=0x%0h WPC=0x%0h rdy=%0b p1=%0b p2=%0b expected RegWr=%0b A3=%0d res=0x%0h WPC=0x%0h rdy=%0b p1=%0b p2=%0b",
                   i, RegWr, A3, res, WPC, aux_ready, q1_pend, q2_pend,
                   vecs[i].ewr, vecs[i].ea3, vecs[i].eres, vecs[i].ewpc,
                   vecs[i].erdy, vecs[i].ep1, vecs[i].ep2);
        end
      end
    end

    // Fill the FIFO under a busy main port, then drain with a cycle budget
    // and confirm enqueue order.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_idle();
      main_we   = 1'b1;
      main_addr = 5'd24;
      main_data = 32'h90 + 32'(k);
      main_pc   = 32'h900 + 32'(k);
      aux_valid = 1'b1;
      aux_addr  = 5'(16 + k);
      aux_data  = 32'h80 + 32'(k);
      aux_pc    = 32'h800 + 32'(k);
      #2;
      check_bit($sformatf("fill_ready%0d", k), aux_ready, 1'b1);
      check_val($sformatf("fill_a3_%0d", k), 32'(A3), 32'd24);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      drive_idle();
      #2;
      if (RegWr) begin
        got_a3.push_back(A3);
        got_res.push_back(res);
      end
      if (got_a3.size() == 4) break;
    end
    check_val("drain_count", 32'(got_a3.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_a3.size()) begin
        check_val($sformatf("drain_a3_%0d", k), 32'(got_a3[k]), 32'(16 + k));
        check_val($sformatf("drain_res_%0d", k), got_res[k], 32'h80 + 32'(k));
      end
    end
    @(negedge clk);
    drive_idle();
    #2;
    check_bit("drain_idle", RegWr, 1'b0);
    check_bit("drain_ready", aux_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
